// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if
//   Key-event output channel of the PS/2 scan decoder.
//
//   Handshake: the producer raises key_valid with key_code/key_ext/key_release
//   and holds all four unchanged until it sees key_valid && key_ready at a
//   rising clock edge. At that edge the event is transferred. The consumer may
//   drive key_ready at any time, independently of key_valid.
//
//   Signals:
//     key_code     8  scan code of the event
//     key_ext      1  event was E0- or E1-prefixed
//     key_release  1  event was F0-prefixed (break)
//     key_valid    1  event held
//     key_ready    1  consumer accepts
interface ps2_scan_decoder_if;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code,
    output key_ext,
    output key_release,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_ext,
    input  key_release,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Takes complete 11-bit PS/2 frames (one per frame_valid pulse), checks
//   start/stop/odd parity, strips the E0/F0/E1 prefixes and emits one key
//   event per complete scan sequence through a one-entry valid/ready buffer.
//   Keyboard status bytes are reported separately and bad frames are counted.
//
//   Ports:
//     clk           in   system clock, rising edge
//     reset_n       in   synchronous active-low reset
//     frame_in      in   [0] start, [8:1] data LSB-first, [9] parity, [10] stop
//     frame_valid   in   one-cycle pulse qualifying frame_in
//     key           master modport: key_code/key_ext/key_release/key_valid/key_ready
//     status_code   out  last status byte
//     status_valid  out  one-cycle pulse with status_code
//     frame_err     out  one-cycle pulse after a bad frame
//     err_count     out  saturating bad-frame count
//     overflow      out  sticky: a key event was dropped
//     clr_overflow  in   clears overflow (a simultaneous set wins)
//     state_dbg     out  current decode state
module ps2_scan_decoder #(
  parameter int ERR_CNT_W  = 8,
  parameter int PAUSE_SKIP = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [10:0]          frame_in,
  input  logic                 frame_valid,
  ps2_scan_decoder_if.master   key,
  output logic [7:0]           status_code,
  output logic                 status_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic [2:0]           state_dbg
);

  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [SKIP_W-1:0] skip_cnt, skip_next;

  logic [7:0] data_byte;
  logic       good_frame;
  logic       byte_ok;

  logic       emit;
  logic [7:0] emit_code;
  logic       emit_ext;
  logic       emit_rel;
  logic       is_status;

  assign data_byte  = frame_in[8:1];
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign good_frame = ~frame_in[0] & frame_in[10] & (^frame_in[9:1]);
  assign byte_ok    = frame_valid & good_frame;
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    emit       = 1'b0;
    emit_code  = data_byte;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    is_status  = 1'b0;
    if (byte_ok) begin
      case (state)
        ST_IDLE: begin
          case (data_byte)
            8'hE0: state_next = ST_EXT;
            8'hF0: state_next = ST_BRK;
            8'hE1: begin
              state_next = ST_PAUSE;
              skip_next  = SKIP_W'(PAUSE_SKIP);
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_status = 1'b1;
            default: emit = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (data_byte == 8'hF0) begin
            state_next = ST_EXT_BRK;
          end else if (data_byte != 8'hE0) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (data_byte != 8'hF0) begin
            emit       = 1'b1;
            emit_rel   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (data_byte != 8'hF0) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            emit_rel   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          // The whole Pause sequence collapses into a single E1 event once
          // the trailing bytes have been swallowed.
          if (skip_cnt <= SKIP_W'(1)) begin
            skip_next  = '0;
            emit       = 1'b1;
            emit_code  = 8'hE1;
            emit_ext   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            skip_next = skip_cnt - SKIP_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status_code  <= '0;
      status_valid <= 1'b0;
      frame_err    <= 1'b0;
      err_count    <= '0;
    end else begin
      status_valid <= is_status;
      if (is_status) status_code <= data_byte;
      frame_err <= frame_valid & ~good_frame;
      if (frame_valid && !good_frame && err_count != {ERR_CNT_W{1'b1}})
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  // One-entry output buffer. A slot is free when empty or being drained this
  // edge; a new event arriving with the slot busy is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key.key_code    <= '0;
      key.key_ext     <= 1'b0;
      key.key_release <= 1'b0;
      key.key_valid   <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (emit && (!key.key_valid || key.key_ready)) begin
        key.key_code    <= emit_code;
        key.key_ext     <= emit_ext;
        key.key_release <= emit_rel;
        key.key_valid   <= 1'b1;
      end else if (key.key_valid && key.key_ready) begin
        key.key_valid <= 1'b0;
      end

      if (emit && key.key_valid && !key.key_ready)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

endmodule
